// File: rtl/blit_pkg.sv
// Shared types and helpers for the blitter address sequencer.
// Holds the FSM state and ALU operation enums, the default widths and the signed-step helper.
package blit_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int CNT_W_DEF  = 8;
    localparam int STEP_W     = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INNER    = 2'd1,
        STEPPING = 2'd2,
        FINISH   = 2'd3
    } blit_state_e;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_INC  = 2'd1,
        OP_DEC  = 2'd2,
        OP_STEP = 2'd3
    } blit_op_e;

    // Two's-complement step, one bit wider than STEP so that -255 is representable.
    function automatic logic [STEP_W:0] signed_step(input logic [STEP_W-1:0] step,
                                                    input logic              stepm1);
        logic [STEP_W:0] mag;
        mag = {1'b0, step};
        return stepm1 ? ({(STEP_W+1){1'b0}} - mag) : mag;
    endfunction

endpackage

// File: rtl/blit_addr_alu.sv
// Combinational address adder for the blitter sequencer.
// It selects one of hold, +1, -1 or +/-STEP. The result wraps modulo 2^ADDR_W.
module blit_addr_alu
    import blit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  blit_op_e          i_op,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_stepm1,
    output logic [ADDR_W-1:0] o_addr
);

    logic [STEP_W:0]     w_sstep;
    logic [ADDR_W-1:0]   w_sstep_ext;
    logic [ADDR_W-1:0]   w_one;

    assign w_sstep     = signed_step(i_step, i_stepm1);
    assign w_sstep_ext = {{(ADDR_W-STEP_W-1){w_sstep[STEP_W]}}, w_sstep};
    assign w_one       = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Next-address selection
    always_comb begin
        o_addr = i_addr;
        case (i_op)
            OP_HOLD: o_addr = i_addr;
            OP_INC:  o_addr = i_addr + w_one;
            OP_DEC:  o_addr = i_addr - w_one;
            OP_STEP: o_addr = i_addr + w_sstep_ext;
            default: o_addr = i_addr;
        endcase
    end

endmodule

// File: rtl/blit_addr_seq.sv
// Blitter address sequencer: runs of +/-1 moves separated by a programmed step.
// Half-rate (YFRAC) stepping exists only when BLIT_STEP_FRAC_EN is defined.
module blit_addr_seq
    import blit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              MasterClock,
    input  logic              RESETL,
    input  logic              ADDR_LD,
    input  logic [ADDR_W-1:0] ADDR_IN,
    input  logic [CNT_W-1:0]  INCNT,
    input  logic [CNT_W-1:0]  OUTCNT,
    input  logic              DECR,
    input  logic [STEP_W-1:0] STEP,
    input  logic              STEPM1,
    input  logic              YFRAC,
    input  logic              START,
    input  logic              ADV,
    output logic [ADDR_W-1:0] ADDR,
    output logic              ACTIVE,
    output logic              RUN_END,
    output logic              DONE
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    blit_state_e       r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_in_cnt;
    logic [CNT_W-1:0]  r_out_cnt;
    logic [CNT_W-1:0]  r_sh_incnt;
    logic              r_sh_decr;
    logic [STEP_W-1:0] r_sh_step;
    logic              r_sh_stepm1;
    logic              r_run_end;
    logic              r_done;
    logic              r_active;

    blit_state_e       w_state_nx;
    blit_op_e          w_op;
    logic [ADDR_W-1:0] w_alu_addr;
    logic [ADDR_W-1:0] w_addr_nx;
    logic [CNT_W-1:0]  w_in_nx;
    logic [CNT_W-1:0]  w_out_nx;
    logic              w_run_end_nx;
    logic              w_done_nx;
    logic              w_start;
    logic              w_load;
    logic              w_step_en;

`ifdef BLIT_STEP_FRAC_EN
    logic r_sh_yfrac;
    logic r_phase;

    // First boundary of each pair is skipped in half-rate mode
    assign w_step_en = r_sh_yfrac ? r_phase : 1'b1;

    // Half-rate phase: cleared on start, toggled on every run boundary
    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            r_sh_yfrac <= 1'b0;
            r_phase    <= 1'b0;
        end else if (w_start) begin
            r_sh_yfrac <= YFRAC;
            r_phase    <= 1'b0;
        end else if (r_state == STEPPING) begin
            r_sh_yfrac <= r_sh_yfrac;
            r_phase    <= ~r_phase;
        end else begin
            r_sh_yfrac <= r_sh_yfrac;
            r_phase    <= r_phase;
        end
    end
`else
    logic w_unused_yfrac;
    assign w_unused_yfrac = YFRAC;
    assign w_step_en      = 1'b1;
`endif

    blit_addr_alu #(.ADDR_W(ADDR_W)) u_alu (
        .i_addr   (r_addr),
        .i_op     (w_op),
        .i_step   (r_sh_step),
        .i_stepm1 (r_sh_stepm1),
        .o_addr   (w_alu_addr)
    );

    assign w_addr_nx = w_load ? ADDR_IN : w_alu_addr;

    // Next-state, counter and address-operation decode
    always_comb begin
        w_state_nx   = r_state;
        w_op         = OP_HOLD;
        w_in_nx      = r_in_cnt;
        w_out_nx     = r_out_cnt;
        w_run_end_nx = 1'b0;
        w_done_nx    = 1'b0;
        w_start      = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                w_load = ADDR_LD;
                if (START) begin
                    w_start    = 1'b1;
                    w_in_nx    = INCNT;
                    w_out_nx   = OUTCNT;
                    w_state_nx = INNER;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            INNER: begin
                if (ADV) begin
                    w_op    = r_sh_decr ? OP_DEC : OP_INC;
                    w_in_nx = r_in_cnt - CNT_ONE;
                    if (r_in_cnt == CNT_ONE) begin
                        w_run_end_nx = 1'b1;
                        w_state_nx   = STEPPING;
                    end else begin
                        w_state_nx   = INNER;
                    end
                end else begin
                    w_state_nx = INNER;
                end
            end
            STEPPING: begin
                if (r_out_cnt == CNT_ONE) begin
                    w_done_nx  = 1'b1;
                    w_state_nx = FINISH;
                end else begin
                    w_out_nx   = r_out_cnt - CNT_ONE;
                    w_in_nx    = r_sh_incnt;
                    w_op       = w_step_en ? OP_STEP : OP_HOLD;
                    w_state_nx = INNER;
                end
            end
            FINISH: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // State, address, counters and registered status outputs
    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            r_state   <= IDLE;
            r_addr    <= {ADDR_W{1'b0}};
            r_in_cnt  <= {CNT_W{1'b0}};
            r_out_cnt <= {CNT_W{1'b0}};
            r_run_end <= 1'b0;
            r_done    <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_addr    <= w_addr_nx;
            r_in_cnt  <= w_in_nx;
            r_out_cnt <= w_out_nx;
            r_run_end <= w_run_end_nx;
            r_done    <= w_done_nx;
            r_active  <= (w_state_nx == INNER) || (w_state_nx == STEPPING);
        end
    end

    // Shadow copy of the step latch so its inputs may change mid-sequence
    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            r_sh_incnt  <= {CNT_W{1'b0}};
            r_sh_decr   <= 1'b0;
            r_sh_step   <= {STEP_W{1'b0}};
            r_sh_stepm1 <= 1'b0;
        end else if (w_start) begin
            r_sh_incnt  <= INCNT;
            r_sh_decr   <= DECR;
            r_sh_step   <= STEP;
            r_sh_stepm1 <= STEPM1;
        end else begin
            r_sh_incnt  <= r_sh_incnt;
            r_sh_decr   <= r_sh_decr;
            r_sh_step   <= r_sh_step;
            r_sh_stepm1 <= r_sh_stepm1;
        end
    end

    assign ADDR    = r_addr;
    assign ACTIVE  = r_active;
    assign RUN_END = r_run_end;
    assign DONE    = r_done;

endmodule

// File: tb/tb_blit_addr_seq.sv
// Self-checking bench for blit_addr_seq: randomized ADV, stall-time commands and latch inputs.
// The expected trace comes from an event-list model of runs and boundaries.
module tb_blit_addr_seq;

    localparam int AW = 20;
    localparam int CW = 8;

    logic          clk;
    logic          RESETL;
    logic          ADDR_LD;
    logic [AW-1:0] ADDR_IN;
    logic [CW-1:0] INCNT;
    logic [CW-1:0] OUTCNT;
    logic          DECR;
    logic [7:0]    STEP;
    logic          STEPM1;
    logic          YFRAC;
    logic          START;
    logic          ADV;
    logic [AW-1:0] ADDR;
    logic          ACTIVE;
    logic          RUN_END;
    logic          DONE;

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        logic [AW-1:0] a;
        bit            re;
        int            kind;   // 0 = inner move, 1 = step boundary, 2 = final boundary
    } ev_t;

    ev_t evq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    blit_addr_seq #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .MasterClock (clk),
        .RESETL      (RESETL),
        .ADDR_LD     (ADDR_LD),
        .ADDR_IN     (ADDR_IN),
        .INCNT       (INCNT),
        .OUTCNT      (OUTCNT),
        .DECR        (DECR),
        .STEP        (STEP),
        .STEPM1      (STEPM1),
        .YFRAC       (YFRAC),
        .START       (START),
        .ADV         (ADV),
        .ADDR        (ADDR),
        .ACTIVE      (ACTIVE),
        .RUN_END     (RUN_END),
        .DONE        (DONE)
    );

    task automatic run_seq(input logic [AW-1:0] base, input logic [CW-1:0] incnt,
                           input logic [CW-1:0] outcnt, input logic decr,
                           input logic [7:0] step, input logic stepm1, input logic yfrac,
                           input int adv_pct, input bit ld_with_start, input int abort_at,
                           output logic [AW-1:0] fin, output int n_re, output int n_dn);
        int            len;
        int            runs;
        int            k;
        int            cyc;
        bit            yf;
        bit            adv_v;
        bit            stalled;
        logic [AW-1:0] a;
        logic [AW-1:0] prev;
        logic [AW+2:0] exp_v;
        logic [AW+2:0] got_v;
        len  = (incnt == 0) ? 256 : int'(incnt);
        runs = (outcnt == 0) ? 256 : int'(outcnt);
        fin  = base;
        n_re = 0;
        n_dn = 0;
`ifdef BLIT_STEP_FRAC_EN
        yf = yfrac;
`else
        yf = 1'b0;
`endif
        evq.delete();
        a = base;
        for (int r = 0; r < runs; r++) begin
            for (int i = 0; i < len; i++) begin
                a = decr ? a - 20'd1 : a + 20'd1;
                evq.push_back('{a, (i == len - 1), 0});
            end
            if (r == runs - 1) begin
                evq.push_back('{a, 1'b0, 2});
            end else begin
                if (!yf || (r % 2 == 1))
                    a = stepm1 ? a - {12'd0, step} : a + {12'd0, step};
                evq.push_back('{a, 1'b0, 1});
            end
        end

        if (!ld_with_start) begin
            @(negedge clk);
            ADDR_LD = 1'b1;
            ADDR_IN = base;
            @(posedge clk);
            #1;
            n_chk++;
            if (ADDR !== base) begin
                n_err++;
                $display("FAIL load: ADDR got %h want %h", ADDR, base);
            end
        end
        @(negedge clk);
        ADDR_LD = ld_with_start;
        ADDR_IN = base;
        INCNT   = incnt;
        OUTCNT  = outcnt;
        DECR    = decr;
        STEP    = step;
        STEPM1  = stepm1;
        YFRAC   = yfrac;
        START   = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        got_v = {ADDR, RUN_END, DONE, ACTIVE};
        exp_v = {base, 3'b001};
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL start: {ADDR,RUN_END,DONE,ACTIVE} got %h want %h", got_v, exp_v);
        end

        prev = base;
        k    = 0;
        cyc  = 0;
        while (k < evq.size() && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            adv_v   = ($urandom_range(99) < adv_pct);
            ADV     = adv_v;
            INCNT   = CW'($urandom);
            OUTCNT  = CW'($urandom);
            DECR    = 1'($urandom);
            STEP    = 8'($urandom);
            STEPM1  = 1'($urandom);
            YFRAC   = 1'($urandom);
            stalled = (evq[k].kind == 0) && !adv_v;
            if (stalled && ($urandom_range(1) == 1)) begin
                START   = 1'b1;
                ADDR_LD = 1'b1;
                ADDR_IN = 20'hABCDE;
            end else begin
                START   = 1'b0;
                ADDR_LD = 1'b0;
            end
            @(posedge clk);
            if (k == abort_at) begin
                #2;
                RESETL = 1'b0;
                #1;
                n_chk++;
                got_v = {ADDR, RUN_END, DONE, ACTIVE};
                if (got_v !== {(AW+3){1'b0}}) begin
                    n_err++;
                    $display("FAIL async_reset: {ADDR,RUN_END,DONE,ACTIVE} got %h want 0", got_v);
                end
                START   = 1'b0;
                ADDR_LD = 1'b0;
                ADV     = 1'b0;
                return;
            end
            #1;
            if (stalled) begin
                exp_v = {prev, 3'b001};
            end else begin
                exp_v = {evq[k].a, evq[k].re, (evq[k].kind == 2), (evq[k].kind != 2)};
                prev  = evq[k].a;
                k++;
            end
            got_v = {ADDR, RUN_END, DONE, ACTIVE};
            n_chk++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL trace[%0d]: {ADDR,RUN_END,DONE,ACTIVE} got %h want %h", k, got_v, exp_v);
            end
            if (RUN_END === 1'b1) n_re++;
            if (DONE === 1'b1) n_dn++;
        end
        if (k < evq.size()) begin
            n_chk++;
            n_err++;
            $display("FAIL timeout: reached event %0d want %0d", k, evq.size());
        end
        @(negedge clk);
        ADV     = 1'b0;
        START   = 1'b0;
        ADDR_LD = 1'b0;
        @(posedge clk);
        #1;
        n_chk++;
        got_v = {ADDR, RUN_END, DONE, ACTIVE};
        exp_v = {prev, 3'b000};
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL idle_after: {ADDR,RUN_END,DONE,ACTIVE} got %h want %h", got_v, exp_v);
        end
        fin = ADDR;
    endtask

    task automatic test_reset();
        logic [AW+2:0] got_v;
        #2;
        RESETL = 1'b0;
        #1;
        n_chk++;
        got_v = {ADDR, RUN_END, DONE, ACTIVE};
        if (got_v !== {(AW+3){1'b0}}) begin
            n_err++;
            $display("FAIL reset: outputs got %h want 0", got_v);
        end
        repeat (2) @(negedge clk);
        RESETL = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        got_v = {ADDR, RUN_END, DONE, ACTIVE};
        if (got_v !== {(AW+3){1'b0}}) begin
            n_err++;
            $display("FAIL reset_idle: outputs got %h want 0", got_v);
        end
    endtask

    task automatic test_basic();
        logic [AW-1:0] fin;
        int            re;
        int            dn;
        run_seq(20'h01000, 8'd4, 8'd2, 1'b0, 8'h10, 1'b0, 1'b0, 100, 1'b0, -1, fin, re, dn);
        n_chk++;
        if (fin !== 20'h01018 || re != 2 || dn != 1) begin
            n_err++;
            $display("FAIL basic: fin %h re %0d dn %0d want 01018 2 1", fin, re, dn);
        end
    endtask

    task automatic test_neg_wrap();
        logic [AW-1:0] fin;
        int            re;
        int            dn;
        run_seq(20'h00002, 8'd3, 8'd2, 1'b1, 8'd5, 1'b1, 1'b0, 100, 1'b0, -1, fin, re, dn);
        n_chk++;
        if (fin !== 20'hFFFF7 || re != 2 || dn != 1) begin
            n_err++;
            $display("FAIL neg_wrap: fin %h re %0d dn %0d want FFFF7 2 1", fin, re, dn);
        end
    endtask

    task automatic test_yfrac();
        logic [AW-1:0] fin;
        logic [AW-1:0] want;
        int            re;
        int            dn;
`ifdef BLIT_STEP_FRAC_EN
        want = 20'h0000C;
`else
        want = 20'h0001C;
`endif
        run_seq(20'h00000, 8'd1, 8'd4, 1'b0, 8'd8, 1'b0, 1'b1, 100, 1'b0, -1, fin, re, dn);
        n_chk++;
        if (fin !== want || re != 4) begin
            n_err++;
            $display("FAIL yfrac: fin %h re %0d want %h 4", fin, re, want);
        end
    endtask

    task automatic test_stall();
        logic [AW-1:0] fin;
        int            re;
        int            dn;
        run_seq(20'h01000, 8'd4, 8'd2, 1'b0, 8'h10, 1'b0, 1'b0, 35, 1'b0, -1, fin, re, dn);
        n_chk++;
        if (fin !== 20'h01018 || dn != 1) begin
            n_err++;
            $display("FAIL stall: fin %h dn %0d want 01018 1", fin, dn);
        end
    endtask

    task automatic test_zero_counts();
        logic [AW-1:0] fin;
        logic [AW-1:0] base;
        int            re;
        int            dn;
        base = AW'($urandom);
        run_seq(base, 8'd0, 8'd1, 1'b0, 8'($urandom), 1'($urandom), 1'b0, 100, 1'b0, -1, fin, re, dn);
        n_chk++;
        if (fin !== base + 20'd256 || re != 1 || dn != 1) begin
            n_err++;
            $display("FAIL zero_counts: fin %h re %0d dn %0d want %h 1 1", fin, re, dn, base + 20'd256);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] fin;
        int            re;
        int            dn;
        int            runs;
        for (int it = 0; it < 8; it++) begin
            runs = int'($urandom_range(6, 1));
            run_seq(AW'($urandom), 8'($urandom_range(6, 1)), 8'(runs), 1'($urandom),
                    8'($urandom), 1'($urandom), 1'($urandom), 60, bit'(it % 2), -1, fin, re, dn);
            n_chk++;
            if (re != runs || dn != 1) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: re %0d dn %0d want %0d 1", it, re, dn, runs);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [AW-1:0] fin;
        logic [AW+2:0] got_v;
        int            re;
        int            dn;
        run_seq(20'h05555, 8'd6, 8'd3, 1'b0, 8'd3, 1'b0, 1'b0, 100, 1'b0, 3, fin, re, dn);
        repeat (2) @(negedge clk);
        RESETL = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        got_v = {ADDR, RUN_END, DONE, ACTIVE};
        if (got_v !== {(AW+3){1'b0}}) begin
            n_err++;
            $display("FAIL reset_release_idle: outputs got %h want 0", got_v);
        end
        run_seq(20'h00100, 8'd2, 8'd2, 1'b0, 8'd4, 1'b0, 1'b0, 100, 1'b0, -1, fin, re, dn);
        n_chk++;
        if (fin !== 20'h00108 || dn != 1) begin
            n_err++;
            $display("FAIL after_reset_run: fin %h dn %0d want 00108 1", fin, dn);
        end
    endtask

    initial begin
        RESETL  = 1'b1;
        ADDR_LD = 1'b0;
        ADDR_IN = '0;
        INCNT   = '0;
        OUTCNT  = '0;
        DECR    = 1'b0;
        STEP    = '0;
        STEPM1  = 1'b0;
        YFRAC   = 1'b0;
        START   = 1'b0;
        ADV     = 1'b0;
        test_reset();
        test_basic();
        test_neg_wrap();
        test_yfrac();
        test_stall();
        test_zero_counts();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
